uart_int_ctrl: RTL and testbench

Interrupt-driven I/O controller between the UART receiver/LED port and the MIPS CPU core. It buffers received bytes in a small FIFO, and raises the CPU interrupt line once per buffered byte. It presents the head byte until the control unit acknowledges it, and enforces a low gap on the interrupt line so every byte produces a distinct edge. It also owns the LED output register written by the CPU.

---
 rtl/uart_int_pkg.sv | 18 +
 rtl/uart_int_ctrl_byte_fifo.sv | 70 +++++++
 rtl/uart_int_ctrl.sv | 102 ++++++++++
 tb/tb_uart_int_ctrl.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_int_pkg.sv
// uart_int_pkg: shared types and defaults for the UART interrupt controller.
//   BYTE_W         data byte width
//   DEF_DEPTH      default receive FIFO depth (power of two, >= 2)
//   DEF_GAP_CYCLES default low-gap length on int0 after each acknowledge (>= 1)
//   state_t        interrupt handshake FSM states
package uart_int_pkg;

    localparam int BYTE_W         = 8;
    localparam int DEF_DEPTH      = 4;
    localparam int DEF_GAP_CYCLES = 2;

    typedef enum logic [1:0] {
        IDLE,
        ASSERT,
        GAP
    } state_t;

endpackage

// File: rtl/uart_int_ctrl_byte_fifo.sv
// byte_fifo: byte FIFO with occupancy count and drop detection for the UART path.
//   clk_i    system clock, rising edge
//   rst_ni   asynchronous active-low reset (empties the FIFO)
//   push_i   write request, data_i is stored if space exists or a pop coincides
//   data_i   byte to store
//   pop_i    remove the head byte (ignored when empty)
//   head_o   head byte, 0 when empty
//   count_o  occupancy, 0..DEPTH
//   empty_o  count_o == 0
//   drop_o   push_i was refused because the FIFO was full with no pop
module byte_fifo
    import uart_int_pkg::*;
#(
    parameter int DEPTH = DEF_DEPTH
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   push_i,
    input  logic [BYTE_W-1:0]      data_i,
    input  logic                   pop_i,
    output logic [BYTE_W-1:0]      head_o,
    output logic [$clog2(DEPTH):0] count_o,
    output logic                   empty_o,
    output logic                   drop_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [BYTE_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic              full, push_ok, pop_ok;

    assign empty_o = count_q == '0;
    // DEPTH is a power of two, so the count MSB is set only when full
    assign full    = count_q[AW];
    assign pop_ok  = pop_i && !empty_o;
    // a pop in the same cycle frees the slot the push lands in
    assign push_ok = push_i && (!full || pop_ok);
    assign drop_o  = push_i && !push_ok;

    always_comb begin
        wr_ptr_d = push_ok ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop_ok ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d  = count_q + CW'(push_ok) - CW'(pop_ok);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // storage needs no reset: empty_o masks stale contents
    always_ff @(posedge clk_i) begin
        if (push_ok) mem_q[wr_ptr_q] <= data_i;
    end

    assign head_o  = empty_o ? '0 : mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/uart_int_ctrl.sv
// uart_int_ctrl: buffers UART bytes and interrupts the CPU once per byte; owns the LED register.
//   clk_i             system clock, rising edge
//   rst_ni            asynchronous active-low reset
//   rx_valid_i        one-cycle strobe, rx_byte_i valid
//   rx_byte_i         received byte
//   int0_o            registered interrupt request to the CPU
//   uart_read_end_i   CPU acknowledge: head byte consumed
//   uart_read_byte_o  FIFO head byte, 0 when empty (combinational)
//   leds_write_i      LED write strobe
//   leds_write_byte_i LED data
//   leds_o            LED register
//   overflow_o        sticky flag, a received byte was dropped
//   ovf_clr_i         clears overflow_o (a simultaneous drop wins)
//   count_o           FIFO occupancy
module uart_int_ctrl
    import uart_int_pkg::*;
#(
    parameter int DEPTH      = DEF_DEPTH,
    parameter int GAP_CYCLES = DEF_GAP_CYCLES
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   rx_valid_i,
    input  logic [BYTE_W-1:0]      rx_byte_i,
    output logic                   int0_o,
    input  logic                   uart_read_end_i,
    output logic [BYTE_W-1:0]      uart_read_byte_o,
    input  logic                   leds_write_i,
    input  logic [BYTE_W-1:0]      leds_write_byte_i,
    output logic [BYTE_W-1:0]      leds_o,
    output logic                   overflow_o,
    input  logic                   ovf_clr_i,
    output logic [$clog2(DEPTH):0] count_o
);

    localparam int GW = $clog2(GAP_CYCLES + 1);

    state_t            state_q, state_d;
    logic [GW-1:0]     gap_q, gap_d;
    logic              int0_q;
    logic              ovf_q, ovf_d;
    logic [BYTE_W-1:0] leds_q, leds_d;
    logic              pop, drop, empty;

    // an acknowledge only counts while the interrupt is being presented
    assign pop = (state_q == ASSERT) && uart_read_end_i;

    byte_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (rx_valid_i),
        .data_i  (rx_byte_i),
        .pop_i   (pop),
        .head_o  (uart_read_byte_o),
        .count_o (count_o),
        .empty_o (empty),
        .drop_o  (drop)
    );

    always_comb begin
        state_d = state_q;
        gap_d   = gap_q;
        case (state_q)
            IDLE:    if (!empty) state_d = ASSERT;
            ASSERT: begin
                if (uart_read_end_i) begin
                    state_d = GAP;
                    gap_d   = GW'(GAP_CYCLES);
                end
            end
            GAP: begin
                // leaving as the counter reaches 0 gives GAP_CYCLES+1 low cycles overall
                gap_d = gap_q - 1'b1;
                if (gap_d == '0) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        ovf_d  = drop | (ovf_q & ~ovf_clr_i);
        leds_d = leds_write_i ? leds_write_byte_i : leds_q;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            gap_q   <= '0;
            int0_q  <= 1'b0;
            ovf_q   <= 1'b0;
            leds_q  <= '0;
        end else begin
            state_q <= state_d;
            gap_q   <= gap_d;
            int0_q  <= state_d == ASSERT;
            ovf_q   <= ovf_d;
            leds_q  <= leds_d;
        end
    end

    assign int0_o     = int0_q;
    assign overflow_o = ovf_q;
    assign leds_o     = leds_q;

endmodule

// File: tb/tb_uart_int_ctrl.sv
// tb_uart_int_ctrl: self-checking bench for uart_int_ctrl with a byte scoreboard.
module tb_uart_int_ctrl;

    logic       clk_i = 1'b0;
    logic       rst_ni = 1'b1;
    logic       rx_valid_i = 1'b0;
    logic [7:0] rx_byte_i = '0;
    logic       int0_o;
    logic       uart_read_end_i = 1'b0;
    logic [7:0] uart_read_byte_o;
    logic       leds_write_i = 1'b0;
    logic [7:0] leds_write_byte_i = '0;
    logic [7:0] leds_o;
    logic       overflow_o;
    logic       ovf_clr_i = 1'b0;
    logic [2:0] count_o;

    uart_int_ctrl #(.DEPTH(4), .GAP_CYCLES(2)) dut (
        .clk_i             (clk_i),
        .rst_ni            (rst_ni),
        .rx_valid_i        (rx_valid_i),
        .rx_byte_i         (rx_byte_i),
        .int0_o            (int0_o),
        .uart_read_end_i   (uart_read_end_i),
        .uart_read_byte_o  (uart_read_byte_o),
        .leds_write_i      (leds_write_i),
        .leds_write_byte_i (leds_write_byte_i),
        .leds_o            (leds_o),
        .overflow_o        (overflow_o),
        .ovf_clr_i         (ovf_clr_i),
        .count_o           (count_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic       we;
        logic [7:0] data;
        logic [7:0] exp;
    } led_vec_t;

    led_vec_t   lv[6];
    logic [7:0] sb[$];
    int         mc = 0;
    int         checks = 0;
    int         errors = 0;

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push(logic [7:0] b);
        rx_valid_i = 1'b1;
        rx_byte_i  = b;
        step();
        rx_valid_i = 1'b0;
        if (mc < 4) begin
            sb.push_back(b);
            mc++;
        end
    endtask

    task automatic wait_int();
        int n = 0;
        while (!int0_o && n < 20) begin
            step();
            n++;
        end
        check("int0 wait", int0_o, 1);
    endtask

    task automatic ack_next();
        logic [7:0] e;
        int n;
        wait_int();
        e = sb.size() > 0 ? sb.pop_front() : 8'h00;
        check("head order", uart_read_byte_o, e);
        uart_read_end_i = 1'b1;
        step();
        uart_read_end_i = 1'b0;
        mc--;
        check("int0 after ack", int0_o, 0);
        check("count after ack", count_o, mc);
        if (mc > 0) begin
            n = 1;
            while (n < 20) begin
                step();
                if (int0_o) break;
                n++;
            end
            check("gap low cycles", n >= 3, 1);
            check("int0 re-rise", int0_o, 1);
        end
    endtask

    initial begin
        lv[0] = '{1'b1, 8'h3C, 8'h3C};
        lv[1] = '{1'b0, 8'hFF, 8'h3C};
        lv[2] = '{1'b0, 8'h00, 8'h3C};
        lv[3] = '{1'b1, 8'h81, 8'h81};
        lv[4] = '{1'b1, 8'h00, 8'h00};
        lv[5] = '{1'b0, 8'hAA, 8'h00};

        #2 rst_ni = 1'b0;
        step();
        step();
        check("rst int0", int0_o, 0);
        check("rst count", count_o, 0);
        check("rst leds", leds_o, 0);
        check("rst overflow", overflow_o, 0);
        check("rst head", uart_read_byte_o, 0);
        rst_ni = 1'b1;
        step();

        // single byte: int0 two edges after the strobe
        push(8'hA5);
        check("A5 count", count_o, 1);
        check("A5 int0 at E0", int0_o, 0);
        step();
        check("A5 int0 at E1", int0_o, 1);
        ack_next();
        repeat (4) step();
        check("int0 stays low", int0_o, 0);

        // back-to-back bytes drained in order with gaps
        push(8'h01);
        push(8'h02);
        push(8'h03);
        check("three count", count_o, 3);
        repeat (3) ack_next();

        // overflow on the fifth byte
        for (int i = 0; i < 5; i++) push(8'hB0 + 8'(i));
        check("ovf count", count_o, 4);
        check("ovf flag", overflow_o, 1);
        ovf_clr_i = 1'b1;
        step();
        ovf_clr_i = 1'b0;
        check("ovf cleared", overflow_o, 0);
        ovf_clr_i = 1'b1;
        push(8'hEE);
        ovf_clr_i = 1'b0;
        check("ovf set wins", overflow_o, 1);
        check("ovf set count", count_o, 4);
        ovf_clr_i = 1'b1;
        step();
        ovf_clr_i = 1'b0;
        check("ovf cleared again", overflow_o, 0);

        // full FIFO, push coincident with ack is accepted
        begin
            logic [7:0] e;
            wait_int();
            e = sb.pop_front();
            check("full head", uart_read_byte_o, e);
            rx_valid_i      = 1'b1;
            rx_byte_i       = 8'h55;
            uart_read_end_i = 1'b1;
            step();
            rx_valid_i      = 1'b0;
            uart_read_end_i = 1'b0;
            sb.push_back(8'h55);
            check("full push+pop count", count_o, 4);
            check("full push+pop ovf", overflow_o, 0);
        end
        repeat (4) ack_next();

        // ack during GAP is ignored
        push(8'h11);
        push(8'h22);
        wait_int();
        check("gap test head", uart_read_byte_o, 8'h11);
        void'(sb.pop_front());
        uart_read_end_i = 1'b1;
        step();
        mc--;
        check("gap test first ack", count_o, 1);
        step();
        uart_read_end_i = 1'b0;
        check("ack in GAP count", count_o, 1);
        check("ack in GAP int0", int0_o, 0);
        check("ack in GAP head", uart_read_byte_o, 8'h22);
        ack_next();

        // ack during IDLE is ignored
        repeat (5) step();
        rx_valid_i      = 1'b1;
        rx_byte_i       = 8'h33;
        uart_read_end_i = 1'b1;
        step();
        rx_valid_i      = 1'b0;
        uart_read_end_i = 1'b0;
        sb.push_back(8'h33);
        mc++;
        check("ack in IDLE count", count_o, 1);
        ack_next();

        // asynchronous reset while interrupting with bytes queued
        leds_write_i      = 1'b1;
        leds_write_byte_i = 8'hF0;
        push(8'h77);
        leds_write_i = 1'b0;
        push(8'h78);
        wait_int();
        check("pre-rst leds", leds_o, 8'hF0);
        #3 rst_ni = 1'b0;
        #1;
        check("async rst int0", int0_o, 0);
        check("async rst count", count_o, 0);
        check("async rst leds", leds_o, 0);
        check("async rst head", uart_read_byte_o, 0);
        sb.delete();
        mc = 0;
        step();
        rst_ni = 1'b1;
        step();

        // LED register vectors
        for (int i = 0; i < 6; i++) begin
            leds_write_i      = lv[i].we;
            leds_write_byte_i = lv[i].data;
            step();
            check($sformatf("leds vec %0d", i), leds_o, lv[i].exp);
        end
        leds_write_i = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
